fpcvt_serial_loader: RTL and testbench
======================================

Name: fpcvt_serial_loader

Overview:
- Serial-to-parallel front end sitting directly upstream of the 13-bit FPCVT converter.
- Collects a two's-complement sample bit-serially, MSB first, from a framed serial link.
- Presents the sample as a stable parallel word with a valid/ready handshake.
- Double-buffered: the next frame can shift in while the previous word waits to be consumed.

Parameters:
- WIDTH, 13: sample width in bits; must equal the converter's D width.
- CNT_W, 4: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sin_valid  in  1  qualifies sin_bit and sin_start for this cycle.
- sin_start  in  1  with sin_valid, marks sin_bit as the MSB (bit 12) of a new frame.
- sin_bit  in  1  serial data bit.
- d_out  out  WIDTH  parallel sample to the converter's D input; stable while d_valid=1 and d_ready=0.
- d_valid  out  1  d_out holds an unconsumed sample.
- d_ready  in  1  consumer accepts d_out when d_valid and d_ready are both 1.
- busy  out  1  frame shift in progress (state SHIFT).
- ovr  out  1  one-cycle pulse: a completed frame was dropped.
- frame_err  out  1  one-cycle pulse: frame rejected (parity variant only; tied 0 otherwise).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 on a clock edge):
  - state=IDLE, shift register=0, count=0.
  - d_out=0, d_valid=0, busy=0, ovr=0, frame_err=0.
  - rst takes priority over every other input. A frame in progress when reset arrives is discarded.
- FSM states: IDLE, SHIFT.
- IDLE:
  - sin_valid & sin_start: shreg <= {shreg[WIDTH-2:0], sin_bit}, count <= 1, go to SHIFT.
  - sin_valid without sin_start: bit ignored.
- SHIFT:
  - sin_valid & sin_start: restart. The bit loads as the new MSB, count <= 1; partial frame silently discarded.
  - sin_valid & !sin_start: shift the bit in, count <= count+1.
  - sin_valid low: hold; gaps of any length are allowed between bits.
- Frame completion: the cycle in which the WIDTH-th bit is shifted in (count==WIDTH-1 with sin_valid & !sin_start).
  - Next cycle: the assembled word is available for transfer to the output register; state returns to IDLE, count=0.
  - A start bit arriving in the cycle immediately after completion is accepted normally (no dead cycle).
- Output register and latency:
  - The word appears on d_out with d_valid=1 one cycle after the completing bit edge.
  - Latency from last bit sampled to d_valid high: 1 clk.
- Handshake:
  - Transfer occurs on any edge with d_valid & d_ready.
  - d_valid falls the cycle after the transfer unless a new word loads in the same edge.
  - Completion and transfer in the same cycle: the new word loads, d_valid stays 1.
  - d_ready is ignored while d_valid=0.
- Overrun: a frame completes while d_valid=1 and d_ready=0.
  - The new word is dropped and d_out is unchanged.
  - ovr pulses high for 1 cycle.
- d_out is a pure register, bit-for-bit the serial frame. No sign handling; the downstream converter owns sign and magnitude.
- busy = (state==SHIFT).

Optional Feature:
- Macro: FPCVT_SERIAL_PARITY_EN.
- Defined:
  - A frame is WIDTH+1 bits: WIDTH data bits, MSB first, then one even-parity bit over the data.
  - Completion occurs on the parity bit.
  - Parity good: word loads exactly as above.
  - Parity bad: word is discarded and frame_err pulses 1 cycle; d_out and d_valid are unaffected.
  - A frame that is both bad and overrun reports frame_err only.
- Undefined:
  - Frames are exactly WIDTH bits.
  - frame_err is tied to 0.

Test Plan:
1. Reset, then frame 0_0001_1010_0110 (422) with sin_valid every cycle, d_ready=1 → d_valid=1 one cycle after bit 13 with d_out=13'h01A6; d_valid=0 the following cycle.
2. Frame 1_0000_0000_0000 with 3-cycle gaps between bits, d_ready=0 → d_out=13'h1000 held and d_valid=1 for 20 cycles; on d_ready=1, d_valid falls next cycle.
3. Frame 13'h0AAA completed with d_ready=0, then frame 13'h1FFF completed → ovr pulses once, d_out stays 13'h0AAA; a third frame 13'h0001 after d_ready=1 yields d_out=13'h0001.
4. Six bits of one frame, then sin_start with a new frame 13'h006C → d_out=13'h006C, no ovr; also rst asserted mid-frame → all outputs 0 next cycle and the following full frame is received correctly.
5. Completion on the same edge as d_valid & d_ready, frames 13'h006D then 13'h006E back-to-back → d_valid stays 1 continuously, d_out goes 13'h006D → 13'h006E, no ovr.
6. With FPCVT_SERIAL_PARITY_EN: 13'h01A6 plus parity 1 → d_out=13'h01A6; the same data with parity 0 → frame_err pulse, d_valid stays 0.

Source files
------------

// File: rtl/fpcvt_serial_loader.sv
// Bit-serial (MSB first) to parallel front end for the FPCVT converter, with a
// double-buffered valid/ready output. Define FPCVT_SERIAL_PARITY_EN for even-parity frames.
module fpcvt_serial_loader #(
   parameter int WIDTH = 13,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin_valid,
   input  logic             sin_start,
   input  logic             sin_bit,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             busy,
   output logic             ovr,
   output logic             frame_err
);

   typedef enum logic {IDLE, SHIFT} state_t;

`ifdef FPCVT_SERIAL_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_dvalid;
   logic             r_ovr;
   logic             r_ferr;

   logic [WIDTH-1:0] w_shift_in;
   logic [WIDTH-1:0] w_word;
   logic             w_par_ok;
   logic             w_complete;
   logic             w_accept;

   assign w_shift_in = {r_shreg[WIDTH-2:0], sin_bit};

`ifdef FPCVT_SERIAL_PARITY_EN
   // Completing bit is the parity bit; the data word is already in the shift register.
   assign w_word   = r_shreg;
   assign w_par_ok = ~^{r_shreg, sin_bit};
`else
   logic w_unused_msb;
   assign w_unused_msb = r_shreg[WIDTH-1];
   assign w_word   = w_shift_in;
   assign w_par_ok = 1'b1;
`endif

   assign w_complete = (r_state == SHIFT) && sin_valid && !sin_start && (r_count == LAST_CNT);
   // The output slot is free if empty or being consumed on this same edge.
   assign w_accept   = !r_dvalid || d_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shreg  <= '0;
         r_count  <= '0;
         r_dout   <= '0;
         r_dvalid <= 1'b0;
         r_ovr    <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
         if (r_dvalid && d_ready)
            r_dvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (sin_valid && sin_start) begin
                  r_shreg <= w_shift_in;
                  r_count <= CNT_W'(1);
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (sin_valid) begin
                  r_shreg <= w_shift_in;
                  if (sin_start) begin
                     r_count <= CNT_W'(1);
                  end else if (w_complete) begin
                     r_count <= '0;
                     r_state <= IDLE;
                     if (!w_par_ok) begin
                        r_ferr <= 1'b1;
                     end else if (w_accept) begin
                        r_dout   <= w_word;
                        r_dvalid <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                  end else begin
                     r_count <= r_count + CNT_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign d_out     = r_dout;
   assign d_valid   = r_dvalid;
   assign busy      = (r_state == SHIFT);
   assign ovr       = r_ovr;
   assign frame_err = r_ferr;

endmodule

// File: tb/tb_fpcvt_serial_loader.sv
// Randomized and directed bench for fpcvt_serial_loader against a frame-level
// reference model (bit queue per frame). Honours FPCVT_SERIAL_PARITY_EN.
module tb_fpcvt_serial_loader;

   localparam int WIDTH = 13;
`ifdef FPCVT_SERIAL_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sin_valid = 1'b0;
   logic             sin_start = 1'b0;
   logic             sin_bit = 1'b0;
   logic             d_ready = 1'b0;
   logic [WIDTH-1:0] d_out;
   logic             d_valid;
   logic             busy;
   logic             ovr;
   logic             frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int               m_bits[$];
   bit               m_active = 0;
   logic [WIDTH-1:0] m_dout = '0;
   bit               m_dvalid = 0;
   bit               m_ovr = 0;
   bit               m_ferr = 0;

   fpcvt_serial_loader #(.WIDTH(WIDTH), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_start(sin_start),
      .sin_bit(sin_bit), .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready),
      .busy(busy), .ovr(ovr), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit   was_valid;
      int   word;
      int   ones;
      if (rst) begin
         m_bits.delete();
         m_active = 0; m_dout = '0; m_dvalid = 0; m_ovr = 0; m_ferr = 0;
         return;
      end
      m_ovr = 0; m_ferr = 0;
      was_valid = m_dvalid;
      if (m_dvalid && d_ready) m_dvalid = 0;
      if (sin_valid) begin
         if (sin_start) begin
            m_bits.delete();
            m_bits.push_back(int'(sin_bit));
            m_active = 1;
         end else if (m_active) begin
            m_bits.push_back(int'(sin_bit));
         end
      end
      if (m_active && m_bits.size() == FRAME) begin
         word = 0; ones = 0;
         for (int i = 0; i < FRAME; i++) begin
            if (i < WIDTH) word = word * 2 + m_bits[i];
            ones += m_bits[i];
         end
         if (ones % 2 != 0 && FRAME != WIDTH) m_ferr = 1;
         else if (was_valid && !d_ready)     m_ovr = 1;
         else begin
            m_dout = WIDTH'(word);
            m_dvalid = 1;
         end
         m_bits.delete();
         m_active = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("d_out", 32'(d_out), 32'(m_dout));
      check("d_valid", 32'(d_valid), 32'(m_dvalid));
      check("busy", 32'(busy), 32'(m_active));
      check("ovr", 32'(ovr), 32'(m_ovr));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
   endtask

   task automatic idle(input int n);
      sin_valid = 0; sin_start = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input bit bad_par);
      logic [FRAME-1:0] f;
`ifdef FPCVT_SERIAL_PARITY_EN
      f = {w, (^w) ^ bad_par};
`else
      f = w;
      if (bad_par) f = w;
`endif
      for (int i = FRAME - 1; i >= 0; i--) begin
         sin_valid = 1; sin_start = (i == FRAME - 1); sin_bit = f[i];
         tick();
         if (i != 0) idle(gap);
      end
      sin_valid = 0; sin_start = 0;
   endtask

   initial begin
      logic [WIDTH-1:0] rw;
      rst = 1; tick(); tick();
      check("reset_d_out", 32'(d_out), 32'h0);
      check("reset_d_valid", 32'(d_valid), 32'h0);
      rst = 0;

      // 1: back-to-back bits, consumer ready
      d_ready = 1;
      send_frame(13'h01A6, 0, 0);
      check("tp1_dout", 32'(d_out), 32'h01A6);
      check("tp1_valid", 32'(d_valid), 32'h1);
      idle(1);
      check("tp1_valid_fall", 32'(d_valid), 32'h0);

      // 2: gapped frame held while consumer stalls
      d_ready = 0;
      send_frame(13'h1000, 3, 0);
      idle(20);
      check("tp2_hold", 32'(d_out), 32'h1000);
      check("tp2_hold_valid", 32'(d_valid), 32'h1);
      d_ready = 1; idle(1);
      check("tp2_fall", 32'(d_valid), 32'h0);

      // 3: overrun
      d_ready = 0;
      send_frame(13'h0AAA, 0, 0);
      send_frame(13'h1FFF, 1, 0);
      check("tp3_ovr", 32'(ovr), 32'h1);
      check("tp3_keep", 32'(d_out), 32'h0AAA);
      d_ready = 1; idle(1);
      send_frame(13'h0001, 0, 0);
      check("tp3_new", 32'(d_out), 32'h0001);

      // 4: restart mid-frame, then reset mid-frame
      for (int i = 0; i < 6; i++) begin
         sin_valid = 1; sin_start = (i == 0); sin_bit = 1'($urandom);
         tick();
      end
      send_frame(13'h006C, 0, 0);
      check("tp4_restart", 32'(d_out), 32'h006C);
      check("tp4_no_ovr", 32'(ovr), 32'h0);
      d_ready = 0;
      for (int i = 0; i < 5; i++) begin
         sin_valid = 1; sin_start = (i == 0); sin_bit = 1'($urandom);
         tick();
      end
      sin_valid = 0; rst = 1; tick(); rst = 0;
      check("tp4_rst_valid", 32'(d_valid), 32'h0);
      check("tp4_rst_busy", 32'(busy), 32'h0);
      send_frame(13'h1234, 1, 0);
      check("tp4_after_rst", 32'(d_out), 32'h1234);

      // 5: completion coincides with transfer
      d_ready = 1;
      send_frame(13'h006D, 0, 0);
      send_frame(13'h006E, 0, 0);
      check("tp5_dout", 32'(d_out), 32'h006E);
      check("tp5_valid", 32'(d_valid), 32'h1);
      idle(1);

`ifdef FPCVT_SERIAL_PARITY_EN
      // 6: parity good then bad
      send_frame(13'h01A6, 0, 0);
      check("tp6_good", 32'(d_out), 32'h01A6);
      idle(1);
      send_frame(13'h01A6, 0, 1);
      check("tp6_ferr", 32'(frame_err), 32'h1);
      check("tp6_novalid", 32'(d_valid), 32'h0);
`endif

      // randomized frames with gaps and random consumer
      for (int k = 0; k < 60; k++) begin
         rw = WIDTH'($urandom);
         d_ready = 1'($urandom);
         send_frame(rw, $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
         idle($urandom_range(0, 3));
      end

      // fully random bit-level stimulus
      for (int k = 0; k < 4000; k++) begin
         rst       = ($urandom_range(0, 499) == 0);
         sin_valid = ($urandom_range(0, 9) < 7);
         sin_start = ($urandom_range(0, 19) == 0);
         sin_bit   = 1'($urandom);
         d_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
